// File: rtl/div_clk_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : div_clk_monitor_if
// Purpose  : Control and measurement bundle between a divided-clock monitor
//            and its user.
// Revision : 1.0 - initial release
// ============================================================================
interface div_clk_monitor_if #(
  parameter int CNT_W = 8
);
  logic             i_en;
  logic             i_div_clk;
  logic             i_err_clr;
  logic             o_rise;
  logic             o_fall;
  logic [CNT_W-1:0] o_high_len;
  logic [CNT_W-1:0] o_low_len;
  logic [CNT_W:0]   o_period;
  logic             o_meas_valid;
  logic             o_locked;
  logic             o_err;

  modport master (
    output i_en, i_div_clk, i_err_clr,
    input  o_rise, o_fall, o_high_len, o_low_len, o_period,
           o_meas_valid, o_locked, o_err
  );

  modport slave (
    input  i_en, i_div_clk, i_err_clr,
    output o_rise, o_fall, o_high_len, o_low_len, o_period,
           o_meas_valid, o_locked, o_err
  );
endinterface
`default_nettype wire

// File: rtl/div_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : div_clk_monitor
// Purpose  : Samples a divided clock as data, emits edge strobes, measures
//            high/low/period run lengths and reports lock and sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module div_clk_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_HIGH = 2,
  parameter int EXP_LOW  = 2,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  div_clk_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    HALF  = 2'd2,
    TRACK = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] c_run_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_run_pre  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_exp_high = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] c_exp_low  = CNT_W'(EXP_LOW);
  localparam logic [CNT_W-1:0] c_tol      = CNT_W'(TOL);
  localparam logic [3:0]       c_lock_cnt = 4'(LOCK_CNT);

  state_e           state_q,    state_d;
  logic             div_q;
  logic [CNT_W-1:0] run_cnt_q,  run_cnt_d;
  logic [3:0]       lock_cnt_q, lock_cnt_d;
  logic             rise_q,     rise_d;
  logic             fall_q,     fall_d;
  logic [CNT_W-1:0] high_q,     high_d;
  logic [CNT_W-1:0] low_q,      low_d;
  logic [CNT_W:0]   period_q,   period_d;
  logic             meas_q,     meas_d;
  logic             locked_q,   locked_d;
  logic             err_q,      err_d;

  logic             w_edge;
  logic             w_rise_edge;
  logic             w_fall_edge;
  logic             w_stuck;
  logic             w_good;
  logic             w_err_set;

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign w_edge      = bus.i_div_clk != div_q;
  assign w_rise_edge = bus.i_div_clk & ~div_q;
  assign w_fall_edge = ~bus.i_div_clk & div_q;
  // Counter is about to saturate without the input ever toggling.
  assign w_stuck     = !w_edge && (run_cnt_q == c_run_pre);
  // On a rising edge in TRACK, run_cnt_q holds the low run just completed.
  assign w_good      = (abs_diff(high_q, c_exp_high) <= c_tol) &&
                       (abs_diff(run_cnt_q, c_exp_low) <= c_tol);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      div_q      <= 1'b0;
      run_cnt_q  <= '0;
      lock_cnt_q <= '0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      high_q     <= '0;
      low_q      <= '0;
      period_q   <= '0;
      meas_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= bus.i_div_clk;
      run_cnt_q  <= run_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      high_q     <= high_d;
      low_q      <= low_d;
      period_q   <= period_d;
      meas_q     <= meas_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    lock_cnt_d = lock_cnt_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    high_d     = high_q;
    low_d      = low_q;
    period_d   = period_q;
    meas_d     = 1'b0;
    locked_d   = locked_q;
    w_err_set  = 1'b0;

    if (state_q == IDLE) begin
      run_cnt_d = '0;
    end else if (w_edge) begin
      run_cnt_d = c_one;
    end else if (run_cnt_q != c_run_max) begin
      run_cnt_d = run_cnt_q + c_one;
    end

    if (!bus.i_en) begin
      state_d    = IDLE;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      rise_d = (state_q != IDLE) && w_rise_edge;
      fall_d = (state_q != IDLE) && w_fall_edge;
      case (state_q)
        IDLE: begin
          state_d = ACQ;
        end
        ACQ: begin
          if (w_rise_edge) begin
            state_d = HALF;
          end
        end
        HALF: begin
          if (w_fall_edge) begin
            high_d  = run_cnt_q;
            state_d = TRACK;
          end else if (w_stuck) begin
            w_err_set  = 1'b1;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            state_d    = ACQ;
          end
        end
        TRACK: begin
          if (w_fall_edge) begin
            high_d = run_cnt_q;
          end else if (w_rise_edge) begin
            low_d    = run_cnt_q;
            period_d = {1'b0, high_q} + {1'b0, run_cnt_q};
            meas_d   = 1'b1;
            if (w_good) begin
              lock_cnt_d = (lock_cnt_q == c_lock_cnt) ? lock_cnt_q
                                                      : lock_cnt_q + 4'd1;
              locked_d   = (lock_cnt_d == c_lock_cnt);
            end else begin
              lock_cnt_d = '0;
              locked_d   = 1'b0;
              w_err_set  = 1'b1;
            end
          end else if (w_stuck) begin
            w_err_set  = 1'b1;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            state_d    = ACQ;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // A new error in the same cycle as a clear request still sets the flag.
    err_d = w_err_set | (err_q & ~bus.i_err_clr);
  end

  assign bus.o_rise       = rise_q;
  assign bus.o_fall       = fall_q;
  assign bus.o_high_len   = high_q;
  assign bus.o_low_len    = low_q;
  assign bus.o_period     = period_q;
  assign bus.o_meas_valid = meas_q;
  assign bus.o_locked     = locked_q;
  assign bus.o_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_clk_monitor
// Purpose  : Directed stimulus with a queue-based scoreboard for
//            div_clk_monitor measurements and strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_clk_monitor;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic [8:0] per;
    logic       lk;
    logic       er;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n_rise;
  int   n_fall;
  logic prev_rise, prev_fall, h1, h2;
  exp_t sb_q[$];

  div_clk_monitor_if #(.CNT_W(8)) bus ();

  div_clk_monitor #(
    .CNT_W(8), .EXP_HIGH(2), .EXP_LOW(2), .TOL(0), .LOCK_CNT(4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int h, input int l, input int p,
                      input logic lk, input logic er);
    exp_t e;
    e.hi  = 8'(h);
    e.lo  = 8'(l);
    e.per = 9'(p);
    e.lk  = lk;
    e.er  = er;
    sb_q.push_back(e);
  endtask

  task automatic drv(input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.i_div_clk = d;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    settle();
    cmp({tag, "_rise"},   32'(bus.o_rise),       0);
    cmp({tag, "_fall"},   32'(bus.o_fall),       0);
    cmp({tag, "_high"},   32'(bus.o_high_len),   0);
    cmp({tag, "_low"},    32'(bus.o_low_len),    0);
    cmp({tag, "_period"}, 32'(bus.o_period),     0);
    cmp({tag, "_meas"},   32'(bus.o_meas_valid), 0);
    cmp({tag, "_locked"}, 32'(bus.o_locked),     0);
    cmp({tag, "_err"},    32'(bus.o_err),        0);
  endtask

  // Monitor: pops one expectation per published measurement and checks strobes
  // are single-cycle and trail the input transition by one cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_meas_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_meas actual=high %0d low %0d required=none",
                 bus.o_high_len, bus.o_low_len);
      end else begin
        e = sb_q.pop_front();
        cmp("meas_high",   32'(bus.o_high_len), 32'(e.hi));
        cmp("meas_low",    32'(bus.o_low_len),  32'(e.lo));
        cmp("meas_period", 32'(bus.o_period),   32'(e.per));
        cmp("meas_locked", 32'(bus.o_locked),   32'(e.lk));
        cmp("meas_err",    32'(bus.o_err),      32'(e.er));
      end
    end
    if (bus.o_rise) begin
      n_rise++;
      cmp("rise_width", 32'(prev_rise), 0);
      cmp("rise_align", 32'({h2, h1}), 32'd1);
    end
    if (bus.o_fall) begin
      n_fall++;
      cmp("fall_width", 32'(prev_fall), 0);
      cmp("fall_align", 32'({h2, h1}), 32'd2);
    end
    prev_rise = bus.o_rise;
    prev_fall = bus.o_fall;
    h2 = h1;
    h1 = bus.i_div_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0; n_rise = 0; n_fall = 0;
    prev_rise = 1'b0; prev_fall = 1'b0; h1 = 1'b0; h2 = 1'b0;
    rst = 1'b1;
    bus.i_en = 1'b0;
    bus.i_div_clk = 1'b0;
    bus.i_err_clr = 1'b0;
    repeat (3) @(posedge clk);
    chk_zero("reset");

    // Nominal 2/2 pattern: six measurements, lock on the fourth.
    for (int k = 1; k <= 6; k++) push(2, 2, 4, k >= 4, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; bus.i_en = 1'b1; bus.i_div_clk = 1'b0;
    n_rise = 0; n_fall = 0;
    drv(0, 1);
    for (int k = 0; k < 6; k++) begin drv(1, 2); drv(0, 2); end
    drv(1, 2);
    settle();
    cmp("nominal_rise_count", 32'(n_rise), 7);
    cmp("nominal_fall_count", 32'(n_fall), 6);

    // One stretched high run, then relock.
    push(2, 2, 4, 1'b1, 1'b0);
    push(5, 2, 7, 1'b0, 1'b1);
    push(2, 2, 4, 1'b0, 1'b1);
    push(2, 2, 4, 1'b0, 1'b1);
    push(2, 2, 4, 1'b0, 1'b1);
    push(2, 2, 4, 1'b1, 1'b1);
    push(2, 2, 4, 1'b1, 1'b1);
    drv(0, 2); drv(1, 5); drv(0, 2);
    for (int k = 0; k < 5; k++) begin drv(1, 2); drv(0, 2); end
    drv(1, 2);

    // Clear the error, then hold low until the run counter saturates.
    drv(0, 20);
    settle();
    cmp("err_before_clr", 32'(bus.o_err), 1);
    @(posedge clk); #1; bus.i_err_clr = 1'b1;
    @(posedge clk); #1; bus.i_err_clr = 1'b0;
    settle();
    cmp("err_after_clr", 32'(bus.o_err), 0);
    cmp("locked_before_stuck", 32'(bus.o_locked), 1);
    drv(0, 280);
    settle();
    cmp("stuck_err", 32'(bus.o_err), 1);
    cmp("stuck_locked", 32'(bus.o_locked), 0);
    cmp("stuck_high_hold", 32'(bus.o_high_len), 2);

    // Restore: ACQ discards the first rise, then relock.
    for (int k = 1; k <= 5; k++) push(2, 2, 4, k >= 4, 1'b1);
    for (int k = 0; k < 5; k++) begin drv(1, 2); drv(0, 2); end
    drv(1, 2);

    // Drop enable mid-high run, toggle input while idle, re-enable.
    settle();
    cmp("locked_before_disable", 32'(bus.o_locked), 1);
    @(posedge clk); #1; bus.i_en = 1'b0; bus.i_div_clk = 1'b1;
    n_rise = 0; n_fall = 0;
    drv(0, 1);
    settle();
    cmp("disable_unlock", 32'(bus.o_locked), 0);
    drv(0, 1);
    @(posedge clk); #1; bus.i_en = 1'b1; bus.i_div_clk = 1'b0;
    drv(0, 1);
    settle();
    cmp("idle_rise_count", 32'(n_rise), 0);
    cmp("idle_fall_count", 32'(n_fall), 0);
    cmp("idle_err_hold", 32'(bus.o_err), 1);
    push(2, 2, 4, 1'b0, 1'b1);
    push(2, 2, 4, 1'b0, 1'b1);
    drv(1, 2); drv(0, 2); drv(1, 2); drv(0, 2); drv(1, 2);

    // Reach lock again with the error set, then reset mid-high run.
    push(2, 2, 4, 1'b0, 1'b1);
    push(2, 2, 4, 1'b1, 1'b1);
    drv(0, 2); drv(1, 2); drv(0, 2); drv(1, 2);
    settle();
    cmp("pre_reset_err", 32'(bus.o_err), 1);
    cmp("pre_reset_locked", 32'(bus.o_locked), 1);
    @(posedge clk); #1; rst = 1'b1; bus.i_div_clk = 1'b1;
    @(posedge clk); #1; rst = 1'b0; bus.i_div_clk = 1'b0;
    chk_zero("midrun_reset");

    // Fresh rise/fall/rise after reset, then a bad low run with a clear.
    push(2, 2, 4, 1'b0, 1'b0);
    push(2, 2, 4, 1'b0, 1'b0);
    push(2, 4, 6, 1'b0, 1'b1);
    drv(0, 1);
    drv(1, 2); drv(0, 2); drv(1, 2); drv(0, 2); drv(1, 2);
    drv(0, 4);
    @(posedge clk); #1; bus.i_div_clk = 1'b1; bus.i_err_clr = 1'b1;
    @(posedge clk); #1; bus.i_err_clr = 1'b0;
    drv(1, 3);
    settle();
    cmp("set_beats_clear", 32'(bus.o_err), 1);
    drv(1, 5);
    settle();
    cmp("scoreboard_empty", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
